// File: rtl/fpu_div_if.sv
// Start/valid handshake bundle for the sequential single-precision divider.
// The requester drives operands and a start pulse; the divider returns the quotient.
interface fpu_div_if #(
  parameter int SIZE_DATA = 32
);
  logic                 i_start;
  logic [SIZE_DATA-1:0] i_32_a;
  logic [SIZE_DATA-1:0] i_32_b;
  logic [SIZE_DATA-1:0] o_32_div;
  logic                 o_valid;
  logic                 o_busy;

  modport master (
    output i_start, i_32_a, i_32_b,
    input  o_32_div, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_32_a, i_32_b,
    output o_32_div, o_valid, o_busy
  );
endinterface

// File: rtl/fpu_div.sv
// Multicycle IEEE-754 single-precision divider: radix-2 restoring mantissa
// division over 26 cycles, then round-to-nearest-even with flush-to-zero.
module fpu_div #(
  parameter int SIZE_DATA = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  fpu_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, SPEC} state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic [25:0]         q;
  logic [24:0]         rem;
  logic [23:0]         mb;
  logic signed [9:0]   exp_r;
  logic                sign_r;
  logic [31:0]         spec_r;
  logic [31:0]         div_r;
  logic                valid_r;
  logic                busy_r;

  // Operand classification; denormals count as zero.
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
  assign a_exp   = bus.i_32_a[30:23];
  assign b_exp   = bus.i_32_b[30:23];
  assign a_frac  = bus.i_32_a[22:0];
  assign b_frac  = bus.i_32_b[22:0];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign sign_in = bus.i_32_a[31] ^ bus.i_32_b[31];

  logic        is_spec;
  logic [31:0] spec_res;
  always_comb begin
    is_spec  = 1'b1;
    spec_res = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_res = 32'h7FC0_0000;
    else if (b_zero || a_inf)
      spec_res = {sign_in, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      spec_res = {sign_in, 31'd0};
    else
      is_spec = 1'b0;
  end

  logic signed [9:0] e_in;
  assign e_in = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;

  // One restoring step: subtract when the divisor fits, then shift.
  logic        q_bit;
  logic [24:0] rem_sel, rem_next;
  always_comb begin
    q_bit    = (rem >= {1'b0, mb});
    rem_sel  = q_bit ? (rem - {1'b0, mb}) : rem;
    rem_next = rem_sel << 1;
  end

  function automatic logic [31:0] round_pack(input logic sign,
                                             input logic signed [9:0] e,
                                             input logic [25:0] qv,
                                             input logic rem_nz);
    logic [23:0]       man;
    logic              g, st, up;
    logic [24:0]       sum;
    logic signed [9:0] ee;
    if (qv[25]) begin
      man = qv[25:2];
      g   = qv[1];
      st  = qv[0] | rem_nz;
      ee  = e;
    end else begin
      man = qv[24:1];
      g   = qv[0];
      st  = rem_nz;
      ee  = e - 10'sd1;
    end
    up  = g & (st | man[0]);
    sum = {1'b0, man} + {24'd0, up};
    if (sum[24]) begin
      man = 24'h80_0000;
      ee  = ee + 10'sd1;
    end else begin
      man = sum[23:0];
    end
    if (ee >= 10'sd255)
      return {sign, 8'hFF, 23'd0};
    else if (ee <= 10'sd0)
      return {sign, 31'd0};
    else
      return {sign, ee[7:0], man[22:0]};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      q       <= 26'd0;
      rem     <= 25'd0;
      mb      <= 24'd0;
      exp_r   <= 10'sd0;
      sign_r  <= 1'b0;
      spec_r  <= 32'd0;
      div_r   <= 32'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            busy_r <= 1'b1;
            sign_r <= sign_in;
            if (is_spec) begin
              spec_r <= spec_res;
              state  <= SPEC;
            end else begin
              mb    <= {1'b1, b_frac};
              rem   <= {2'b01, a_frac};
              q     <= 26'd0;
              cnt   <= 5'd0;
              exp_r <= e_in;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q   <= {q[24:0], q_bit};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= ROUND;
        end
        ROUND: begin
          div_r   <= round_pack(sign_r, exp_r, q, |rem);
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          div_r   <= spec_r;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_32_div = div_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_busy   = busy_r;

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: directed IEEE cases, randomized operands
// against an exact integer-division reference, handshake and reset scenarios.
module tb_fpu_div;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_div_if #(.SIZE_DATA(32)) bus();
  fpu_div #(.SIZE_DATA(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: exact quotient via integer division, rounded to nearest-even.
  function automatic logic tb_is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic s, az, bz, ai, bi, an, bn;
    longint unsigned ma, mb, sig, r;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0); an = (ea == 255) && (a[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0); bn = (eb == 255) && (b[22:0] != 0);
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
    if (bz || ai) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    ma = 64'h80_0000 + longint'(a[22:0]);
    mb = 64'h80_0000 + longint'(b[22:0]);
    e  = ea - eb + 127;
    if (ma >= mb) begin
      sig = (ma << 23) / mb; r = (ma << 23) % mb;
    end else begin
      sig = (ma << 24) / mb; r = (ma << 24) % mb; e = e - 1;
    end
    if ((2 * r > mb) || ((2 * r == mb) && sig[0])) sig = sig + 1;
    if (sig == 64'h100_0000) begin sig = 64'h80_0000; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] v;
    k = int'($urandom_range(0, 11));
    v = $urandom;
    case (k)
      0: v[30:23] = 8'h00;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'd1 + 23'($urandom_range(0, 1000)); end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Stimulus: drive a start pulse sampled at the next rising edge; returns at the negedge after it.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_32_a = a; bus.i_32_b = b;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int busy_cycles, output logic held);
    logic [31:0] prev;
    prev = bus.o_32_div;
    lat = -1; held = 1'b1;
    busy_cycles = bus.o_busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin lat = i; break; end
      if (bus.o_busy) busy_cycles++;
      if (bus.o_32_div !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_32_a = '0; bus.i_32_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_32_div, bus.o_valid, bus.o_busy} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got div=%h valid=%b busy=%b, want 0/0/0",
               bus.o_32_div, bus.o_valid, bus.o_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [0:10];
    logic [31:0] tb [0:10];
    logic [31:0] te [0:10];
    int          tl [0:10];
    int lat, bc;
    logic held;
    ta = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
           32'h00000000, 32'h7F800000, 32'h7FC00001, 32'h7F000000, 32'h00800000, 32'h80000000};
    tb = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'h00000000,
           32'h00000000, 32'h7F800000, 32'h3F800000, 32'h3E800000, 32'h40000000, 32'h40A00000};
    te = '{32'h40400000, 32'h3EAAAAAB, 32'hBE800000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    tl = '{27, 27, 27, 1, 1, 1, 1, 1, 27, 27, 1};
    for (int i = 0; i < 11; i++) begin
      launch(ta[i], tb[i]);
      wait_valid(lat, bc, held);
      n_checks++;
      if (bus.o_32_div !== te[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: %h/%h got %h want %h", i, ta[i], tb[i], bus.o_32_div, te[i]);
      end
      n_checks++;
      if (lat != tl[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bc != 27) begin
          n_fail++;
          $display("FAIL busy_cycles: got %0d want 27", bc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_pulse_width: valid=%b busy=%b one cycle later, want 0/0", bus.o_valid, bus.o_busy);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp_v;
    int lat, bc, want_lat;
    logic held;
    for (int i = 0; i < 60; i++) begin
      a = rand_op(); b = rand_op();
      exp_v = model_div(a, b);
      want_lat = tb_is_special(a, b) ? 1 : 27;
      launch(a, b);
      wait_valid(lat, bc, held);
      n_checks++;
      if (bus.o_32_div !== exp_v || lat != want_lat || !held) begin
        n_fail++;
        $display("FAIL random[%0d]: %h/%h got %h lat %0d held %b, want %h lat %0d held 1",
                 i, a, b, bus.o_32_div, lat, held, exp_v, want_lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int extra;
    n = 0;
    launch(32'h40C00000, 32'h40000000);
    repeat (4) begin @(negedge clk); n++; end
    bus.i_start = 1'b1; bus.i_32_a = 32'h3F800000; bus.i_32_b = 32'h40400000;
    @(negedge clk); n++;
    bus.i_start = 1'b0;
    while (!bus.o_valid && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 27 || bus.o_32_div !== 32'h40400000) begin
      n_fail++;
      $display("FAIL busy_ignore: got %h at edge %0d, want 40400000 at edge 27", bus.o_32_div, n);
    end
    extra = 0;
    repeat (35) begin @(negedge clk); if (bus.o_valid || bus.o_busy) extra++; end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_ignore_no_rerun: got %0d active cycles after result, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp_v;
    int lat, bc;
    logic held;
    launch(32'h3F800000, 32'h40400000);
    wait_valid(lat, bc, held);
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 32'hBF800000 : rand_op();
      b = (i == 0) ? 32'h40800000 : rand_op();
      exp_v = model_div(a, b);
      bus.i_start = 1'b1; bus.i_32_a = a; bus.i_32_b = b;
      @(negedge clk);
      bus.i_start = 1'b0;
      n_checks++;
      if (bus.o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_accept[%0d]: busy got %b want 1", i, bus.o_busy);
      end
      wait_valid(lat, bc, held);
      n_checks++;
      if (bus.o_32_div !== exp_v || lat != (tb_is_special(a, b) ? 1 : 27)) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: %h/%h got %h lat %0d want %h", i, a, b, bus.o_32_div, lat, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad, lat, bc;
    logic held;
    launch(32'h40C00000, 32'h40000000);
    wait_valid(lat, bc, held);
    launch(32'h3F800000, 32'h40400000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_32_div, bus.o_valid, bus.o_busy} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got div=%h valid=%b busy=%b, want 0/0/0",
               bus.o_32_div, bus.o_valid, bus.o_busy);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (bus.o_valid) bad++; end
    rst_n = 1'b1;
    repeat (35) begin @(negedge clk); if (bus.o_valid || bus.o_busy) bad++; end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %0d active cycles after abort, want 0", bad);
    end
    launch(32'h40C00000, 32'h40000000);
    wait_valid(lat, bc, held);
    n_checks++;
    if (bus.o_32_div !== 32'h40400000 || lat != 27) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %h lat %0d want 40400000 lat 27", bus.o_32_div, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
